// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared hazard controller state encodings and register index type
// Purpose: one place for the FSM state codes and register-index width used by the hazard
//          controller and by the decode/EX stages that share its view of the pipeline.
// Ports:   none (package).
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_LU_STALL = 3'd1;
  localparam logic [2:0] ST_BR_FLUSH = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT = 3'd3;
  localparam logic [2:0] ST_HALTED   = 3'd4;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// rtl/hazard_ctrl_cmp.sv - combinational load-use hazard detect
// Purpose: flags a decode instruction that reads a register a load in EX is about to write.
//          Kept standalone so the same compare can drive forwarding selects later.
// Ports:   rs_valid_i/rt_valid_i, rs_sel_i/rt_sel_i  - decode source operands
//          mem_en_i/mem_write_i/reg_write_i/wr_sel_i - EX instruction control and destination
//          load_use_o                                - hazard detected
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic     rs_valid_i,
  input  logic     rt_valid_i,
  input  reg_idx_t rs_sel_i,
  input  reg_idx_t rt_sel_i,
  input  logic     mem_en_i,
  input  logic     mem_write_i,
  input  logic     reg_write_i,
  input  reg_idx_t wr_sel_i,
  output logic     load_use_o
);

  logic is_load;
  logic src_match;

  // Only a register-writing load produces a value too late for forwarding.
  assign is_load    = mem_en_i & ~mem_write_i & reg_write_i;
  assign src_match  = (rs_valid_i & (rs_sel_i == wr_sel_i)) |
                      (rt_valid_i & (rt_sel_i == wr_sel_i));
  assign load_use_o = is_load & src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (stall/flush for PC, if_id, id_ex, ex_mem)
// Purpose: Mealy controller for load-use bubbles, taken-branch squash, data/instruction memory
//          waits and halt freeze. Optional macro HAZARD_PERF_CNT_EN adds perf_stall_cnt and
//          perf_flush_cnt saturating counters.
// Ports:   clk, rst (async, active-low)
//          id_rs_valid, id_rt_valid, id_reg1_sel, id_reg2_sel            - decode operands
//          ex_memEn, ex_memWrite, ex_regWrite, ex_write_reg, ex_br_taken, ex_halt - EX control
//          dmem_stall, dmem_done, imem_stall                             - memory handshakes
//          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, halted
//          perf_stall_cnt, perf_flush_cnt (HAZARD_PERF_CNT_EN only)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int BR_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_rs_valid,
  input  logic                 id_rt_valid,
  input  logic [REG_IDX_W-1:0] id_reg1_sel,
  input  logic [REG_IDX_W-1:0] id_reg2_sel,
  input  logic                 ex_memEn,
  input  logic                 ex_memWrite,
  input  logic                 ex_regWrite,
  input  logic [REG_IDX_W-1:0] ex_write_reg,
  input  logic                 ex_br_taken,
  input  logic                 ex_halt,
  input  logic                 dmem_stall,
  input  logic                 dmem_done,
  input  logic                 imem_stall,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]          perf_stall_cnt,
  output logic [15:0]          perf_flush_cnt
`endif
);

  localparam int MAX_CYCLES = (LU_CYCLES > BR_CYCLES) ? LU_CYCLES : BR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LU_CYCLES - 1);
  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             load_use;

  hazard_cmp u_cmp (
    .rs_valid_i  (id_rs_valid),
    .rt_valid_i  (id_rt_valid),
    .rs_sel_i    (id_reg1_sel),
    .rt_sel_i    (id_reg2_sel),
    .mem_en_i    (ex_memEn),
    .mem_write_i (ex_memWrite),
    .reg_write_i (ex_regWrite),
    .wr_sel_i    (ex_write_reg),
    .load_use_o  (load_use)
  );

  // Saturating decrement so a stray zero count can never wrap.
  assign cnt_dec = (cnt_q != '0) ? cnt_q - ONE : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    halted       = 1'b0;
    // Outputs are forced low for as long as reset is held, whatever the inputs do.
    if (rst) begin
      // A data-memory wait freezes the whole pipe from any non-halted state; a done in the
      // same cycle completes it immediately.
      if (state_q != ST_HALTED && state_q != ST_MEM_WAIT && dmem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        cnt_d        = '0;
        state_d      = dmem_done ? ST_RUN : ST_MEM_WAIT;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (ex_br_taken) begin
              // Branch wins over a simultaneous load-use: the hazard instr is squashed anyway.
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              if (BR_CYCLES > 1) begin
                state_d = ST_BR_FLUSH;
                cnt_d   = BR_INIT;
              end
            end else if (ex_halt) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
              state_d     = ST_HALTED;
            end else if (load_use) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
              if (LU_CYCLES > 1) begin
                state_d = ST_LU_STALL;
                cnt_d   = LU_INIT;
              end
            end else if (imem_stall) begin
              pc_stall    = 1'b1;
              if_id_flush = 1'b1;
            end
          end
          ST_LU_STALL: begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            cnt_d       = cnt_dec;
            if (cnt_q <= ONE) state_d = ST_RUN;
          end
          ST_BR_FLUSH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cnt_d       = cnt_dec;
            if (cnt_q <= ONE) state_d = ST_RUN;
          end
          ST_MEM_WAIT: begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            if (dmem_done) state_d = ST_RUN;
          end
          ST_HALTED: begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            halted       = 1'b1;
          end
          default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_q;
  logic [15:0] perf_flush_q;
  logic        br_entry;

  // A branch flush is entered only from RUN when no data-memory wait pre-empts it.
  assign br_entry = (state_q == ST_RUN) & ~dmem_stall & ex_br_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall && (state_q != ST_HALTED) && (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
      if (br_entry && (perf_flush_q != 16'hFFFF))
        perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
